// File: rtl/decoder_scan_n.sv
// N-to-2^N one-hot decoder with a registered output. It has two modes: DECODE captures a strobed select; SCAN auto-steps every SCAN_DIV cycles.
// Outputs update one edge after the inputs. There is no backpressure: load is accepted on any cycle with en=1.
module decoder_scan_n #(
   parameter int SEL_W    = 3,
   parameter int SCAN_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  mode,
   input  logic                  load,
   input  logic [SEL_W-1:0]      sel,
   output logic [2**SEL_W-1:0]   f,
   output logic [SEL_W-1:0]      idx,
   output logic                  valid,
   output logic                  wrap
);
   localparam int OUT_W = 2**SEL_W;
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
   localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(OUT_W - 1);
   localparam logic [OUT_W-1:0] ONE     = OUT_W'(1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DECODE = 2'd1;
   localparam logic [1:0] ST_SCAN   = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [DIV_W-1:0] div, div_nxt;
   logic [SEL_W-1:0] idx_nxt;
   logic             wrap_nxt;

   always_comb begin
      state_nxt = !en ? ST_IDLE : (!mode ? ST_DECODE : ST_SCAN);
      idx_nxt   = idx;
      div_nxt   = div;
      wrap_nxt  = 1'b0;
      case (state_nxt)
         ST_DECODE: begin
            if (load) idx_nxt = sel;
            div_nxt = '0;
         end
         ST_SCAN: begin
            // load outranks a coincident step; entering SCAN restarts the divider
            if (load) begin
               idx_nxt = sel;
               div_nxt = '0;
            end else if (state != ST_SCAN) begin
               div_nxt = '0;
            end else if (div == DIV_MAX) begin
               div_nxt  = '0;
               idx_nxt  = idx + SEL_W'(1);
               wrap_nxt = (idx == IDX_MAX);
            end else begin
               div_nxt = div + DIV_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         idx   <= '0;
         div   <= '0;
         f     <= '0;
         valid <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         div   <= div_nxt;
         wrap  <= wrap_nxt;
         if (state_nxt == ST_IDLE) begin
            f     <= '0;
            valid <= 1'b0;
         end else begin
            f     <= ONE << idx_nxt;
            valid <= 1'b1;
         end
      end
   end
endmodule
